// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC fetch controller: FSM states, next-PC
// source codes and the fixed instruction width in bytes.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_JMP  = 2'd2,
        SEL_TRAP = 2'd3
    } pc_sel_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // A redirect target is unusable unless it lands on a word boundary
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: trap beats jump beats branch beats
// sequential. A misaligned jump/branch target is replaced by the trap
// vector and flagged so the controller can raise misalign_err.
module pc_next_sel
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        trap,
    output logic [31:0] next_pc,
    output pc_sel_t     sel,
    output logic        misaligned
);

    // Priority select of the redirect source, then alignment screening
    always_comb begin
        sel        = SEL_SEQ;
        next_pc    = pc + INSTR_BYTES;
        misaligned = 1'b0;
        if (trap) begin
            sel     = SEL_TRAP;
            next_pc = TRAP_VECTOR;
        end else if (jump) begin
            sel = SEL_JMP;
            if (is_misaligned(jump_target)) begin
                misaligned = 1'b1;
                next_pc    = TRAP_VECTOR;
            end else begin
                next_pc = jump_target;
            end
        end else if (branch_taken) begin
            sel = SEL_BR;
            if (is_misaligned(branch_target)) begin
                misaligned = 1'b1;
                next_pc    = TRAP_VECTOR;
            end else begin
                next_pc = branch_target;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_controller.sv
// Multi-cycle fetch/execute sequencer owning the architectural PC.
// BOOT -> FETCH (wait for imem_ready, latch instruction) -> EXEC (wait
// for ex_done or trap) -> FETCH ... with no overlap of fetch and execute.
module pc_fetch_controller
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        ex_done,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        trap,
    output logic        misalign_err,
    output logic [31:0] instret
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] instret_q, instret_d;
    logic        misalign_q, misalign_d;

    logic [31:0] next_pc;
    pc_sel_t     sel;
    logic        misaligned;

    pc_next_sel #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_sel (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .next_pc       (next_pc),
        .sel           (sel),
        .misaligned    (misaligned)
    );

    // Next-state, PC update, instruction latch and retire counting
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        instret_d  = instret_q;
        misalign_d = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (sel == SEL_TRAP) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end else if (!stall && ex_done) begin
                    instret_d  = instret_q + 32'd1;
                    pc_d       = next_pc;
                    misalign_d = misaligned;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            instret_q  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            instret_q  <= instret_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = pc_q;
    assign instr_valid  = (state_q == EXEC);
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instret      = instret_q;
    assign misalign_err = misalign_q;

endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
Sequences the program counter of the RISC-V core through a multi-cycle fetch/execute loop. It issues instruction-memory requests and holds the fetched instruction for the execute stage. It selects the next PC from sequential, branch, jump or trap sources, and counts retired instructions. It owns the core's architectural PC register and sits between the instruction memory port and the decode/execute datapath.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned target.

Ports:
CLK  in  1  core clock; all state updates on rising edge
RST  in  1  asynchronous, active-low reset (0 = reset)
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address (= current PC)
imem_ready  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  latched instruction for decode
instr_pc  out  32  PC of latched instruction
instr_valid  out  1  instr/instr_pc valid for execute
ex_done  in  1  execute finished current instruction (single-cycle pulse)
stall  in  1  hold current instruction, no PC update
branch_taken  in  1  conditional branch resolved taken
branch_target  in  32  branch destination
jump  in  1  JAL/JALR redirect
jump_target  in  32  jump destination
trap  in  1  exception/ecall redirect request
misalign_err  out  1  one-cycle pulse: selected target not word-aligned
instret  out  32  retired-instruction count

Behaviour:
- Reset (RST=0, async): pc=RESET_VECTOR; state=BOOT; imem_req=0, imem_addr=RESET_VECTOR, instr=0, instr_pc=0, instr_valid=0, misalign_err=0, instret=0. Release is sampled on the next CLK edge.
- States: BOOT, FETCH, EXEC.
- BOOT: outputs idle. Moves unconditionally to FETCH on the next edge.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready=1: instr<=imem_rdata, instr_pc<=pc, go to EXEC. Otherwise stay; request and address stay stable. Zero-wait memory costs 1 cycle in FETCH. Branch, jump, trap, ex_done and stall are ignored in FETCH.
- EXEC: instr_valid=1, imem_req=0.
  - trap=1 (ex_done not required): pc<=TRAP_VECTOR, go to FETCH, instret unchanged. Trap overrides stall.
  - Else if stall=1: hold everything, ex_done ignored.
  - Else if ex_done=1: instret<=instret+1, pc<=next_pc, go to FETCH.
  - Else: stay.
- next_pc priority: jump ? jump_target : branch_taken ? branch_target : pc+4.
- pc+4 is mod 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Misalignment: if the selected jump/branch target has [1:0] != 0, pc<=TRAP_VECTOR and misalign_err=1 for exactly the following cycle. The instruction still retires (instret increments). Sequential pc+4 is never misaligned.
- instret wraps 32'hFFFF_FFFF -> 0.
- Latency per instruction = 1 (FETCH, zero-wait) + N_exec cycles in EXEC. No overlap of fetch and execute.
- instr_valid drops in the cycle after leaving EXEC. instr and instr_pc hold their last values until the next imem_ready.
- Reset asserted mid-FETCH or mid-EXEC: immediate return to reset values. The in-flight memory response is discarded; the memory must tolerate imem_req dropping without ready.
- misalign_err is registered; all other outputs are registered or decoded directly from state.

Decomposition:
- Package pc_ctrl_pkg:
  - state encoding (BOOT=2'd0, FETCH=2'd1, EXEC=2'd2)
  - next-PC select codes (SEL_SEQ, SEL_BR, SEL_JMP, SEL_TRAP)
  - INSTR_BYTES=4
- Sub-module pc_next_sel (combinational): inputs pc, branch/jump/trap controls and targets. Outputs next_pc, sel code and misaligned flag. Keeps the priority logic separately testable.
- FSM, PC register, instruction latch and instret live in pc_fetch_controller.

Test Plan:
- Reset release, memory ready at 0 wait, ex_done after 1 EXEC cycle, run 3 instructions -> imem_addr 0x0, 0x4, 0x8; instret=3; instr_pc matches each fetch.
- Memory with 3 wait cycles, stall=1 for 2 EXEC cycles while ex_done pulses -> imem_addr held stable during waits; no retire while stalled; instret increments only on ex_done with stall=0.
- pc=0x40, ex_done with jump=1 (0x200) and branch_taken=1 (0x80) together -> next imem_addr=0x200. Branch alone -> 0x80.
- branch_taken with target 0x102 -> misalign_err high for one cycle, next imem_addr=TRAP_VECTOR 0x100, instret incremented.
- trap=1 in EXEC with stall=1, no ex_done -> next fetch at 0x100, instret unchanged. trap during FETCH -> ignored.
- Test-only PC force to 0xFFFF_FFFC plus ex_done -> next imem_addr=0x0. RST=0 pulsed mid-FETCH (asynchronous, between edges) -> outputs reset immediately; first fetch after release at RESET_VECTOR.
